// File: rtl/disp_cmd_ctrl.sv
// rtl/disp_cmd_ctrl.sv - host command FIFO sequencer and cell RAM write controller
module disp_cmd_ctrl #(
  parameter int ADDR_W     = 13,
  parameter int ADDR_LIMIT = 4800,
  parameter int RD_PULSE   = 2,
  parameter int RD_RECOVER = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [7:0]        disp_cmd_in,
  input  logic              nef_in,
  output logic              disp_cmd_rd,
  input  logic              mem_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cmd_err,
  output logic              idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_WAIT,
    S_RD_LOW,
    S_RD_REC,
    S_DECODE,
    S_WRITE
  } state_t;

  localparam logic [ADDR_W-1:0] LIMIT    = ADDR_W'(ADDR_LIMIT);
  localparam logic [7:0]        PULSE_LD = 8'(RD_PULSE - 1);
  localparam logic [7:0]        REC_LD   = 8'(RD_RECOVER - 1);

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_ADDR_LO  = 8'h01;
  localparam logic [7:0] OP_ADDR_HI  = 8'h02;
  localparam logic [7:0] OP_PUT      = 8'h03;
  localparam logic [7:0] OP_ATTR     = 8'h04;
  localparam logic [7:0] OP_FILL     = 8'h05;

  state_t            state;
  logic [1:0]        nef_sync;
  logic [7:0]        cnt;
  logic [7:0]        rd_byte;
  logic [7:0]        opcode;
  logic              have_op;
  logic [8:0]        fill_cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        cur_attr;
  logic [7:0]        cur_char;
  logic [ADDR_W-1:0] addr_lo_new;
  logic [ADDR_W-1:0] addr_hi_new;
  logic [ADDR_W-1:0] addr_next;

  // Increment with wrap at the last valid cell; wrapping is not an error.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] n;
    n = a + ADDR_W'(1);
    return (n == LIMIT) ? '0 : n;
  endfunction

  // Candidate addresses for the two SET_ADDR operands and the post-write increment.
  always_comb begin
    addr_lo_new = {addr[ADDR_W-1:8], rd_byte};
    addr_hi_new = {rd_byte[ADDR_W-9:0], addr[7:0]};
    addr_next   = addr_inc(addr);
  end

  // Two-flop synchronizer for the asynchronous FIFO non-empty flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) nef_sync <= 2'b00;
    else       nef_sync <= {nef_sync[0], nef_in};
  end

  // Main sequencer: read strobe timing, opcode/operand decode, RAM write handshake.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      disp_cmd_rd <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      cmd_err     <= 1'b0;
      idle        <= 1'b1;
      cnt         <= '0;
      rd_byte     <= '0;
      opcode      <= '0;
      have_op     <= 1'b0;
      fill_cnt    <= '0;
      addr        <= '0;
      cur_attr    <= 8'h0F;
      cur_char    <= 8'h20;
    end else begin
      case (state)
        S_IDLE, S_OP_WAIT: begin
          if (nef_sync[1]) begin
            state       <= S_RD_LOW;
            disp_cmd_rd <= 1'b0;
            cnt         <= PULSE_LD;
            idle        <= 1'b0;
          end
        end

        S_RD_LOW: begin
          if (cnt == 8'd0) begin
            rd_byte     <= disp_cmd_in;
            disp_cmd_rd <= 1'b1;
            cnt         <= REC_LD;
            state       <= S_RD_REC;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_RD_REC: begin
          if (cnt == 8'd0) state <= S_DECODE;
          else             cnt   <= cnt - 8'd1;
        end

        S_DECODE: begin
          if (!have_op) begin
            opcode <= rd_byte;
            case (rd_byte)
              OP_NOP: begin
                state <= S_IDLE;
                idle  <= 1'b1;
              end
              OP_ADDR_LO, OP_ADDR_HI, OP_PUT, OP_ATTR, OP_FILL: begin
                have_op <= 1'b1;
                state   <= S_OP_WAIT;
              end
              default: begin
                cmd_err <= 1'b1;
                state   <= S_IDLE;
                idle    <= 1'b1;
              end
            endcase
          end else begin
            have_op <= 1'b0;
            state   <= S_IDLE;
            idle    <= 1'b1;
            case (opcode)
              OP_ADDR_LO: begin
                if (addr_lo_new >= LIMIT) begin
                  addr    <= '0;
                  cmd_err <= 1'b1;
                end else begin
                  addr <= addr_lo_new;
                end
              end
              OP_ADDR_HI: begin
                if (addr_hi_new >= LIMIT) begin
                  addr    <= '0;
                  cmd_err <= 1'b1;
                end else begin
                  addr <= addr_hi_new;
                end
              end
              OP_PUT: begin
                cur_char <= rd_byte;
                fill_cnt <= 9'd1;
                mem_we   <= 1'b1;
                mem_addr <= addr;
                mem_data <= {cur_attr, rd_byte};
                state    <= S_WRITE;
                idle     <= 1'b0;
              end
              OP_ATTR: begin
                cur_attr <= rd_byte;
              end
              OP_FILL: begin
                fill_cnt <= (rd_byte == 8'd0) ? 9'd256 : {1'b0, rd_byte};
                mem_we   <= 1'b1;
                mem_addr <= addr;
                mem_data <= {cur_attr, cur_char};
                state    <= S_WRITE;
                idle     <= 1'b0;
              end
              default: begin
              end
            endcase
          end
        end

        S_WRITE: begin
          // Outputs stay frozen while the renderer owns the RAM.
          if (!mem_busy) begin
            addr <= addr_next;
            if (fill_cnt == 9'd1) begin
              mem_we <= 1'b0;
              state  <= S_IDLE;
              idle   <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt - 9'd1;
              mem_addr <= addr_next;
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          disp_cmd_rd <= 1'b1;
          mem_we      <= 1'b0;
          idle        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_cmd_ctrl.sv
// tb/tb_disp_cmd_ctrl.sv - randomized scoreboard bench for disp_cmd_ctrl
module tb_disp_cmd_ctrl;

  localparam int RD_PULSE   = 2;
  localparam int RD_RECOVER = 2;
  localparam int LIMIT      = 4800;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  disp_cmd_in = 8'h00;
  logic        nef_in = 1'b0;
  logic        disp_cmd_rd;
  logic        mem_busy = 1'b0;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_data;
  logic        cmd_err;
  logic        idle;

  typedef struct {
    logic [12:0] a;
    logic [15:0] d;
  } wr_t;

  logic [7:0] fifo_q[$];
  wr_t        exp_q[$];

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int m_addr = 0;
  int m_attr = 8'h0F;
  int m_chr = 8'h20;
  int m_err = 0;
  bit busy_rand = 1'b0;

  logic        prev_rd = 1'b1;
  logic        prev_we = 1'b0;
  logic        prev_busy = 1'b0;
  logic [12:0] prev_addr = '0;
  logic [15:0] prev_data = '0;
  int          low_cnt = 0;
  int          high_cnt = 99;
  wr_t         got_w;

  always #5 clk = ~clk;

  disp_cmd_ctrl #(
    .ADDR_W(13), .ADDR_LIMIT(LIMIT), .RD_PULSE(RD_PULSE), .RD_RECOVER(RD_RECOVER)
  ) dut (
    .clk(clk), .nrst(nrst), .disp_cmd_in(disp_cmd_in), .nef_in(nef_in),
    .disp_cmd_rd(disp_cmd_rd), .mem_busy(mem_busy), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .cmd_err(cmd_err), .idle(idle)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // FIFO model: the head byte is presented while non-empty; the read strobe's rising edge consumes it.
  always @(posedge disp_cmd_rd) begin
    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      nef_in = (fifo_q.size() != 0);
      disp_cmd_in = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      mem_busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Monitor: scoreboard pops on accepted writes, plus strobe timing and busy-freeze checks.
  always @(negedge clk) begin
    if (!nrst) begin
      prev_rd = 1'b1;
      prev_we = 1'b0;
      prev_busy = 1'b0;
      low_cnt = 0;
      high_cnt = 99;
    end else begin
      if (mem_we && !mem_busy) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          got_w = exp_q.pop_front();
          check("write_addr", mem_addr, got_w.a);
          check("write_data", mem_data, got_w.d);
        end
      end
      if (prev_we && prev_busy) begin
        check("hold_we", mem_we, 1);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_data", mem_data, prev_data);
      end
      if (mem_we) check("no_strobe_in_write", disp_cmd_rd, 1);
      if (prev_rd && !disp_cmd_rd) begin
        strobes++;
        check("recover_width", high_cnt >= RD_RECOVER, 1);
        check("read_nonempty", fifo_q.size() != 0, 1);
        low_cnt = 1;
      end else if (!prev_rd && disp_cmd_rd) begin
        check("pulse_width", low_cnt, RD_PULSE);
        high_cnt = 1;
      end else if (!disp_cmd_rd) begin
        low_cnt++;
      end else begin
        high_cnt++;
      end
      prev_rd = disp_cmd_rd;
      prev_we = mem_we;
      prev_busy = mem_busy;
      prev_addr = mem_addr;
      prev_data = mem_data;
    end
  end

  function automatic int inc_addr(input int a);
    return (a + 1 == LIMIT) ? 0 : a + 1;
  endfunction

  task automatic push_write();
    wr_t w;
    w.a = m_addr[12:0];
    w.d = {m_attr[7:0], m_chr[7:0]};
    exp_q.push_back(w);
    m_addr = inc_addr(m_addr);
  endtask

  // Reference model: feeds the FIFO and predicts writes/errors from the command rules.
  task automatic cmd(input int op, input int arg);
    int na;
    int n;
    fifo_q.push_back(op[7:0]);
    if (op >= 1 && op <= 5) fifo_q.push_back(arg[7:0]);
    case (op)
      1: begin
        na = (m_addr & 32'h1F00) | (arg & 255);
        if (na >= LIMIT) begin m_addr = 0; m_err = 1; end
        else m_addr = na;
      end
      2: begin
        na = ((arg & 31) << 8) | (m_addr & 255);
        if (na >= LIMIT) begin m_addr = 0; m_err = 1; end
        else m_addr = na;
      end
      3: begin
        m_chr = arg & 255;
        push_write();
      end
      4: m_attr = arg & 255;
      5: begin
        n = ((arg & 255) == 0) ? 256 : (arg & 255);
        for (int i = 0; i < n; i++) push_write();
      end
      0: ;
      default: m_err = 1;
    endcase
  endtask

  task automatic wait_done(input string name);
    int stable;
    int n;
    stable = 0;
    n = 0;
    while (stable < 6 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && idle === 1'b1) stable++;
      else stable = 0;
    end
    check({name, "_done"}, stable >= 6, 1);
  endtask

  initial begin
    int base;
    int n;
    int op;
    int arg;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", disp_cmd_rd, 1);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_err", cmd_err, 0);
    check("rst_idle", idle, 1);
    nrst = 1'b1;

    // Empty FIFO for 100 cycles: no reads, no writes.
    repeat (100) @(posedge clk);
    #1;
    check("empty_strobes", strobes, 0);
    check("empty_idle", idle, 1);
    check("empty_rd", disp_cmd_rd, 1);

    // Basic sequence: six reads, one write at 0x0010.
    base = strobes;
    cmd(1, 8'h10);
    cmd(2, 8'h00);
    cmd(3, 8'h41);
    wait_done("basic");
    check("basic_strobes", strobes - base, 6);
    cmd(3, 8'h44);
    wait_done("basic_next");

    // Last valid cell then wrap to 0.
    cmd(1, 8'hBF);
    cmd(2, 8'h12);
    cmd(3, 8'h42);
    cmd(3, 8'h43);
    wait_done("wrap");
    check("wrap_err", cmd_err, 0);

    // Attribute, put and fills under random busy.
    busy_rand = 1'b1;
    cmd(4, 8'h1E);
    cmd(3, 8'h41);
    cmd(5, 8'h03);
    wait_done("fill3");
    cmd(5, 8'h00);
    wait_done("fill256");
    check("fill_err", cmd_err, 0);

    // Invalid opcode, then out-of-range high byte forces addr to 0.
    cmd(8'h7F, 0);
    wait_done("badop");
    check("badop_err", cmd_err, 1);
    cmd(2, 8'hFF);
    cmd(3, 8'h5A);
    wait_done("badhi");
    check("badhi_err", cmd_err, m_err);

    // Randomized command mix.
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 7);
      if (op >= 6) op = $urandom_range(6, 255);
      case (op)
        2: arg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 18);
        5: arg = $urandom_range(0, 8);
        default: arg = $urandom_range(0, 255);
      endcase
      cmd(op, arg);
      if (k % 10 == 9) begin
        wait_done("rand");
        check("rand_err", cmd_err, m_err);
      end
    end
    busy_rand = 1'b0;

    // Reset during the low phase of an operand read.
    base = strobes;
    fifo_q.push_back(8'h03);
    fifo_q.push_back(8'h55);
    n = 0;
    while (strobes < base + 2 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mid_reached", strobes >= base + 2, 1);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("mid_rd", disp_cmd_rd, 1);
    check("mid_we", mem_we, 0);
    check("mid_idle", idle, 1);
    fifo_q.delete();
    exp_q.delete();
    m_addr = 0;
    m_attr = 8'h0F;
    m_chr = 8'h20;
    m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    cmd(3, 8'h66);
    wait_done("after_rst");
    check("after_rst_err", cmd_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
